// File: rtl/four_req_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four requesters.
//
// Issues a registered one-hot grant and drives the mux select. An owner keeps
// the grant while it requests, but is forced to hand over after HOLD_MAX
// consecutive cycles if anyone else is waiting. Handover to the next waiting
// requester happens on the release edge, with no idle cycle in between.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   req    in   4  request vector, bit i = requester i (mux input d(i+1))
//   gnt    out  4  registered one-hot grant, zero when idle
//   sel    out  2  registered mux select, index of current owner
//   busy   out  1  registered, high while a grant is active
module four_req_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8  // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy
);

    localparam logic [3:0] HoldLast = 4'(HOLD_MAX - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cur_q, cur_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;

    logic [3:0] cur_oh;
    logic [3:0] others;
    logic       owner_done;

    // First set bit of mask, scanning start, start+1, ... modulo 4.
    function automatic logic [1:0] pick(input logic [1:0] start, input logic [3:0] mask);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign cur_oh = 4'b0001 << cur_q;
    // Current owner is excluded so a re-asserted request cannot win its own handover.
    assign others = req & ~cur_oh;
    assign owner_done = !req[cur_q] || ((hold_q == HoldLast) && (others != 4'b0000));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        hold_d  = hold_q;

        case (state_q)
            StIdle: begin
                if (req != 4'b0000) begin
                    cur_d   = pick(ptr_q, req);
                    hold_d  = 4'd0;
                    ptr_d   = cur_d + 2'd1;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (owner_done) begin
                    if (others != 4'b0000) begin
                        cur_d  = pick(cur_q + 2'd1, others);
                        hold_d = 4'd0;
                        ptr_d  = cur_d + 2'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (hold_q != HoldLast) begin
                    // Saturates so a sole requester can hold indefinitely.
                    hold_d = hold_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered copies of the next state so they move together.
        if (state_d == StGrant) begin
            gnt_d  = 4'b0001 << cur_d;
            sel_d  = cur_d;
            busy_d = 1'b1;
        end else begin
            gnt_d  = 4'b0000;
            sel_d  = sel_q;
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
            cur_q   <= 2'd0;
            hold_q  <= 4'd0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_four_req_rr_arbiter.sv
// Scoreboard bench for four_req_rr_arbiter (HOLD_MAX = 8).
// Stimulus pushes the hand-computed expectation for the next edge; a monitor
// pops it just after that edge and compares gnt/sel/busy and the mux output.
module tb_four_req_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;

    logic [7:0] d [4];
    logic [7:0] mux_out;

    int n_checks = 0;
    int n_fail   = 0;
    int step_id  = 0;

    typedef struct {
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        int         id;
    } exp_t;

    exp_t exp_q[$];

    four_req_rr_arbiter #(.HOLD_MAX(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy)
    );

    // Behavioural stand-in for four_mux_one driven by the arbiter's sel.
    assign mux_out = d[sel];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es,
                         input logic eb);
        n_checks++;
        if ({gnt, sel, busy} !== {eg, es, eb}) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b sel=%0d busy=%b, expected gnt=%b sel=%0d busy=%b",
                     name, gnt, sel, busy, eg, es, eb);
        end
    endtask

    // Apply req before the next edge and queue what must appear after it.
    task automatic drive(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] es,
                         input logic eb);
        exp_t e;
        req  = r;
        e.g  = eg;
        e.s  = es;
        e.b  = eb;
        e.id = step_id;
        step_id++;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic drive_n(input int n, input logic [3:0] r, input logic [3:0] eg,
                           input logic [1:0] es, input logic eb);
        for (int i = 0; i < n; i++) drive(r, eg, es, eb);
    endtask

    // Asserts reset between edges and checks outputs clear without a clock edge.
    task automatic do_reset(input string name);
        req   = 4'b0000;
        #1;
        rst_n = 1'b0;
        #1;
        check({name, "_async"}, 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        check({name, "_held"}, 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares one queued expectation per clock edge.
    initial begin
        exp_t e;
        int   owner;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("step%0d", e.id), e.g, e.s, e.b);
                if (e.b) begin
                    owner = 0;
                    for (int i = 0; i < 4; i++) if (e.g[i]) owner = i;
                    n_checks++;
                    if (mux_out !== d[owner]) begin
                        n_fail++;
                        $display("FAIL mux_step%0d: got out=%h, expected %h", e.id, mux_out,
                                 d[owner]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        d[0] = 8'h11;
        d[1] = 8'h22;
        d[2] = 8'h44;
        d[3] = 8'h88;
        #1;
        do_reset("reset0");

        // Idle after reset.
        drive_n(5, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Single requester 2 holds beyond HOLD_MAX with nobody else waiting.
        drive_n(20, 4'b0100, 4'b0100, 2'd2, 1'b1);
        drive_n(2, 4'b0000, 4'b0000, 2'd2, 1'b0);

        // Everyone requesting: 8-cycle slices 0,1,2,3,0 with no gaps.
        do_reset("reset1");
        drive_n(8, 4'b1111, 4'b0001, 2'd0, 1'b1);
        drive_n(8, 4'b1111, 4'b0010, 2'd1, 1'b1);
        drive_n(8, 4'b1111, 4'b0100, 2'd2, 1'b1);
        drive_n(8, 4'b1111, 4'b1000, 2'd3, 1'b1);
        drive_n(8, 4'b1111, 4'b0001, 2'd0, 1'b1);

        // Voluntary release by 0 after 3 cycles; 1 then gets a full 8-cycle slice.
        do_reset("reset2");
        drive_n(3, 4'b0011, 4'b0001, 2'd0, 1'b1);
        drive(4'b0010, 4'b0010, 2'd1, 1'b1);
        drive_n(7, 4'b0011, 4'b0010, 2'd1, 1'b1);
        drive(4'b0011, 4'b0001, 2'd0, 1'b1);

        // Hand to 3, then 3 drops with 0 and 1 waiting: pick wraps to 0.
        drive(4'b1000, 4'b1000, 2'd3, 1'b1);
        drive(4'b1001, 4'b1000, 2'd3, 1'b1);
        drive(4'b0011, 4'b0001, 2'd0, 1'b1);
        drive(4'b0000, 4'b0000, 2'd0, 1'b0);

        // From idle with ptr=1, requester 3 alone; then reset mid-grant.
        drive_n(2, 4'b1000, 4'b1000, 2'd3, 1'b1);
        do_reset("reset_midgrant");
        drive(4'b1010, 4'b0010, 2'd1, 1'b1);
        drive(4'b0000, 4'b0000, 2'd1, 1'b0);

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
